// File: rtl/mcif_axi_slv_mem_if.sv
// AXI4 read/write bus between an mcif_* master and the memory-backed responder.
interface mcif_axi_slv_mem_if #(
    parameter int unsigned ID_W   = 3,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
);
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [31:0]         S_AXI_AWADDR;
    logic [LEN_W-1:0]    S_AXI_AWLEN;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ID_W-1:0]     S_AXI_ARID;
    logic [31:0]         S_AXI_ARADDR;
    logic [LEN_W-1:0]    S_AXI_ARLEN;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/mcif_axi_slv_mem.sv
// AXI4 responder over a single-port synchronous word memory: one INCR burst at a time,
// read/write arbitrated round-robin. Stands in for the DDR controller in VPU sims.
module mcif_axi_slv_mem #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 3,
    parameter int unsigned MEM_AW             = 12,
    parameter int unsigned AXI_DATA_WIDTH     = 64,
    parameter int unsigned LOG2_MAX_BURST_LEN = 8
) (
    input logic               clk,
    input logic               rst_n,
    mcif_axi_slv_mem_if.slave s_axi
);
    localparam int unsigned STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SH = $clog2(STRB_W);
    localparam int unsigned CNT_W   = LOG2_MAX_BURST_LEN + 1;
    localparam int unsigned DEPTH   = 1 << MEM_AW;
    localparam logic        PRI_RD  = 1'b0;
    localparam logic        PRI_WR  = 1'b1;

    typedef enum logic [1:0] {IDLE, RD, WR, WRSP} state_t;

    state_t                        state;
    logic                          rr_pri;
    logic [MEM_AW-1:0]             addr;
    logic [CNT_W-1:0]              beats_left;
    logic                          wlast_err;
    logic                          ar_ready;
    logic                          aw_ready;
    logic                          w_ready;
    logic                          b_valid;
    logic [1:0]                    b_resp;
    logic [C_S_AXI_ID_WIDTH-1:0]   b_id;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0]     r_data;
    logic                          r_last;
    logic                          r_valid;
    logic [AXI_DATA_WIDTH-1:0]     mem [DEPTH];

    logic rd_issue_c;
    logic wr_beat_c;
    logic last_beat_c;

    // A read is issued whenever a beat remains and the output slot is free or draining.
    always_comb begin
        rd_issue_c  = 1'b0;
        wr_beat_c   = 1'b0;
        last_beat_c = (beats_left == CNT_W'(1));
        if (state == RD)
            rd_issue_c = (beats_left != '0) && (!r_valid || s_axi.S_AXI_RREADY);
        if (state == WR)
            wr_beat_c = s_axi.S_AXI_WVALID && w_ready;
    end

    // Byte-enabled write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_beat_c) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (s_axi.S_AXI_WSTRB[b])
                    mem[addr][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_pri     <= PRI_RD;
            addr       <= '0;
            beats_left <= '0;
            wlast_err  <= 1'b0;
            ar_ready   <= 1'b0;
            aw_ready   <= 1'b0;
            w_ready    <= 1'b0;
            b_valid    <= 1'b0;
            b_resp     <= 2'b00;
            b_id       <= '0;
            r_id       <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_ready) begin
                        if (s_axi.S_AXI_ARVALID) begin
                            ar_ready   <= 1'b0;
                            addr       <= MEM_AW'(s_axi.S_AXI_ARADDR >> BYTE_SH);
                            beats_left <= CNT_W'(s_axi.S_AXI_ARLEN) + CNT_W'(1);
                            r_id       <= s_axi.S_AXI_ARID;
                            state      <= RD;
                        end
                    end else if (aw_ready) begin
                        if (s_axi.S_AXI_AWVALID) begin
                            aw_ready   <= 1'b0;
                            addr       <= MEM_AW'(s_axi.S_AXI_AWADDR >> BYTE_SH);
                            beats_left <= CNT_W'(s_axi.S_AXI_AWLEN) + CNT_W'(1);
                            b_id       <= s_axi.S_AXI_AWID;
                            wlast_err  <= 1'b0;
                            w_ready    <= 1'b1;
                            state      <= WR;
                        end
                    end else if (s_axi.S_AXI_ARVALID &&
                                 (!s_axi.S_AXI_AWVALID || rr_pri == PRI_RD)) begin
                        ar_ready <= 1'b1;
                        rr_pri   <= PRI_WR;
                    end else if (s_axi.S_AXI_AWVALID) begin
                        aw_ready <= 1'b1;
                        rr_pri   <= PRI_RD;
                    end
                end
                RD: begin
                    if (rd_issue_c) begin
                        r_data     <= mem[addr];
                        r_valid    <= 1'b1;
                        r_last     <= last_beat_c;
                        addr       <= addr + MEM_AW'(1);
                        beats_left <= beats_left - CNT_W'(1);
                    end else if (r_valid && s_axi.S_AXI_RREADY) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last)
                            state <= IDLE;
                    end
                end
                WR: begin
                    // Burst length comes from AWLEN; a misplaced WLAST only flags SLVERR.
                    if (wr_beat_c) begin
                        addr       <= addr + MEM_AW'(1);
                        beats_left <= beats_left - CNT_W'(1);
                        if (s_axi.S_AXI_WLAST != last_beat_c)
                            wlast_err <= 1'b1;
                        if (last_beat_c) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= (wlast_err || !s_axi.S_AXI_WLAST) ? 2'b10 : 2'b00;
                            state   <= WRSP;
                        end
                    end
                end
                WRSP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        b_valid <= 1'b0;
                        b_resp  <= 2'b00;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BID     = b_id;
    assign s_axi.S_AXI_BRESP   = b_resp;
    assign s_axi.S_AXI_BVALID  = b_valid;
    assign s_axi.S_AXI_ARREADY = ar_ready;
    assign s_axi.S_AXI_RID     = r_id;
    assign s_axi.S_AXI_RDATA   = r_data;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RLAST   = r_last;
    assign s_axi.S_AXI_RVALID  = r_valid;
endmodule

// File: tb/tb_mcif_axi_slv_mem.sv
// Randomized bench for mcif_axi_slv_mem against a word-array reference model.
module tb_mcif_axi_slv_mem;
    localparam int TMO   = 2000;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcif_axi_slv_mem_if #(.ID_W(3), .DATA_W(64), .LEN_W(8)) axi ();

    mcif_axi_slv_mem #(
        .C_S_AXI_ID_WIDTH(3), .MEM_AW(12), .AXI_DATA_WIDTH(64), .LOG2_MAX_BURST_LEN(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .s_axi(axi)
    );

    logic [63:0] model [DEPTH];
    logic [63:0] wdat  [256];
    logic [7:0]  wstb  [256];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 3) & 32'hFFF);
    endfunction

    task automatic check_reset_outputs();
        check("rst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        check("rst_wready",  64'(axi.S_AXI_WREADY),  64'd0);
        check("rst_bvalid",  64'(axi.S_AXI_BVALID),  64'd0);
        check("rst_bresp",   64'(axi.S_AXI_BRESP),   64'd0);
        check("rst_bid",     64'(axi.S_AXI_BID),     64'd0);
        check("rst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
        check("rst_rvalid",  64'(axi.S_AXI_RVALID),  64'd0);
        check("rst_rlast",   64'(axi.S_AXI_RLAST),   64'd0);
        check("rst_rresp",   64'(axi.S_AXI_RRESP),   64'd0);
        check("rst_rid",     64'(axi.S_AXI_RID),     64'd0);
        check("rst_rdata",   axi.S_AXI_RDATA,        64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Write burst from wdat/wstb; wlast_beat < 0 or > len means WLAST never asserted.
    task automatic axi_write(input logic [2:0] id, input logic [31:0] addr, input int len,
                             input int wlast_beat);
        int n;
        int base;
        logic [1:0] exp_resp;
        base     = widx(addr);
        exp_resp = (wlast_beat == len) ? 2'b00 : 2'b10;
        axi.S_AXI_AWID    = id;
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWLEN   = 8'(len);
        axi.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_AWREADY && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin
            check("aw_timeout", 64'd0, 64'd1);
            axi.S_AXI_AWVALID = 1'b0;
            return;
        end
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                axi.S_AXI_WVALID = 1'b0;
                @(negedge clk);
            end
            axi.S_AXI_WDATA  = wdat[i];
            axi.S_AXI_WSTRB  = wstb[i];
            axi.S_AXI_WLAST  = (i == wlast_beat);
            axi.S_AXI_WVALID = 1'b1;
            n = 0;
            while (!axi.S_AXI_WREADY && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) begin
                check("w_timeout", 64'd0, 64'd1);
                axi.S_AXI_WVALID = 1'b0;
                return;
            end
            @(negedge clk);
            for (int b = 0; b < 8; b++)
                if (wstb[i][b]) model[(base + i) % DEPTH][b*8 +: 8] = wdat[i][b*8 +: 8];
        end
        axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_WLAST  = 1'b0;
        check("bvalid_latency", 64'(axi.S_AXI_BVALID), 64'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("bvalid_held", 64'(axi.S_AXI_BVALID), 64'd1);
        check("bresp", 64'(axi.S_AXI_BRESP), 64'(exp_resp));
        check("bid",   64'(axi.S_AXI_BID),   64'(id));
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
        check("bvalid_clear", 64'(axi.S_AXI_BVALID), 64'd0);
    endtask

    // mode 0: RREADY always 1, 1: random, 2: 1010 toggle
    task automatic axi_read(input logic [2:0] id, input logic [31:0] addr, input int len,
                            input int mode);
        int n;
        int got;
        int cyc;
        int base;
        logic rr;
        base = widx(addr);
        axi.S_AXI_ARID    = id;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARLEN   = 8'(len);
        axi.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_ARREADY && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin
            check("ar_timeout", 64'd0, 64'd1);
            axi.S_AXI_ARVALID = 1'b0;
            return;
        end
        @(negedge clk);
        axi.S_AXI_ARVALID = 1'b0;
        check("rvalid_t1", 64'(axi.S_AXI_RVALID), 64'd0);
        @(negedge clk);
        check("rvalid_t2", 64'(axi.S_AXI_RVALID), 64'd1);
        got = 0;
        cyc = 0;
        while (got <= len && cyc < TMO) begin
            case (mode)
                1:       rr = 1'($urandom_range(0, 1));
                2:       rr = (cyc % 2 == 0);
                default: rr = 1'b1;
            endcase
            axi.S_AXI_RREADY = rr;
            if (axi.S_AXI_RVALID) begin
                check("rdata", axi.S_AXI_RDATA, model[(base + got) % DEPTH]);
                check("rlast", 64'(axi.S_AXI_RLAST), 64'(got == len));
                check("rid",   64'(axi.S_AXI_RID),   64'(id));
                if (rr) got++;
            end else if (got > 0) begin
                check("rvalid_gap", 64'(axi.S_AXI_RVALID), 64'd1);
            end
            @(negedge clk);
            cyc++;
        end
        axi.S_AXI_RREADY = 1'b0;
        if (got <= len) check("r_timeout", 64'd0, 64'd1);
        check("rvalid_end", 64'(axi.S_AXI_RVALID), 64'd0);
    endtask

    task automatic fill_random(input int len, input bit full_strb);
        for (int i = 0; i <= len; i++) begin
            wdat[i] = {$urandom, $urandom};
            wstb[i] = (full_strb || $urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int len;
        int wl;
        logic [31:0] a;
        axi.S_AXI_AWID = '0; axi.S_AXI_AWADDR = '0; axi.S_AXI_AWLEN = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARID = '0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARLEN = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;

        do_reset();

        // Preload every word with maximum-length bursts.
        for (int k = 0; k < DEPTH / 256; k++) begin
            fill_random(255, 1'b1);
            axi_write(3'(k), 32'(k * 256 * 8), 255, 255);
        end

        // Fresh reset: read side has priority; memory keeps its contents.
        do_reset();
        axi.S_AXI_ARID = 3'd1; axi.S_AXI_ARADDR = 32'h40; axi.S_AXI_ARLEN = 8'd1;
        axi.S_AXI_AWID = 3'd2; axi.S_AXI_AWADDR = 32'h48; axi.S_AXI_AWLEN = 8'd0;
        axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!(axi.S_AXI_ARREADY || axi.S_AXI_AWREADY) && n < TMO) begin @(negedge clk); n++; end
        check("arb_read_first", 64'({axi.S_AXI_ARREADY, axi.S_AXI_AWREADY}), 64'd2);
        axi_read(3'd1, 32'h40, 1, 0);
        fill_random(0, 1'b1);
        axi_write(3'd2, 32'h48, 0, 0);
        axi_read(3'd3, 32'h40, 1, 0);

        // Last grant was read, so a simultaneous request now goes to write.
        axi.S_AXI_ARID = 3'd4; axi.S_AXI_ARADDR = 32'h80; axi.S_AXI_ARLEN = 8'd0;
        axi.S_AXI_AWID = 3'd5; axi.S_AXI_AWADDR = 32'h80; axi.S_AXI_AWLEN = 8'd0;
        axi.S_AXI_ARVALID = 1'b1; axi.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!(axi.S_AXI_ARREADY || axi.S_AXI_AWREADY) && n < TMO) begin @(negedge clk); n++; end
        check("arb_write_rr", 64'({axi.S_AXI_ARREADY, axi.S_AXI_AWREADY}), 64'd1);
        fill_random(0, 1'b1);
        axi_write(3'd5, 32'h80, 0, 0);
        axi_read(3'd4, 32'h80, 0, 0);

        // A0..A3 at 0x100, then read back streaming and with 1010 RREADY.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 64'hA0 + 64'(i);
            wstb[i] = 8'hFF;
        end
        axi_write(3'd5, 32'h100, 3, 3);
        axi_read(3'd6, 32'h100, 3, 0);
        axi_read(3'd7, 32'h100, 3, 2);

        // Burst wrapping from the last word to word 0 with partial strobe.
        wdat[0] = 64'h1111_2222_3333_4444; wstb[0] = 8'hFF;
        wdat[1] = 64'h5555_6666_7777_8888; wstb[1] = 8'h0F;
        axi_write(3'd2, 32'h7FF8, 1, 1);
        axi_read(3'd2, 32'h7FF8, 1, 0);

        // Misplaced or missing WLAST: full burst still written, SLVERR returned.
        fill_random(2, 1'b1);
        axi_write(3'd3, 32'h200, 2, 1);
        axi_read(3'd3, 32'h200, 2, 1);
        fill_random(2, 1'b1);
        axi_write(3'd4, 32'h300, 2, -1);
        axi_read(3'd4, 32'h300, 2, 0);

        // Randomized mix; upper and low address bits must be ignored.
        for (int t = 0; t < 40; t++) begin
            a   = $urandom;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                fill_random(len, 1'b0);
                wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
                axi_write(3'($urandom), a, len, wl);
            end else begin
                axi_read(3'($urandom), a, len, $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
